sequence_differencer: RTL

Recovers the per-cycle addend stream from the running-sum output of `sequenceAdder`. It is the inverse of that accumulator and feeds the adder's check path. Each accepted sum sample `q` yields `a = q - q_prev` (mod 2^WIDTH), with a one-entry registered output and a valid/ready handshake on both sides. A run detector flags when the recovered addend has been constant for RUN_LEN consecutive samples.

---
 rtl/sequence_differencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/sequence_differencer.sv
// Recovers per-cycle addends from a running-sum stream (inverse of sequenceAdder),
// with a one-entry registered output, valid/ready on both sides and a run detector.
module sequence_differencer #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             steady,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int RUN_CW = $clog2(RUN_LEN + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [RUN_CW-1:0] run_q, run_d;
  logic              steady_q, steady_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic             accept, emit;
  logic [WIDTH-1:0] base, diff;

  assign a_valid    = (state_q == FULL);
  assign q_ready    = (state_q == EMPTY) || a_ready;
  assign accept     = q_valid && q_ready;
  assign emit       = a_valid && a_ready;
  assign a          = a_q;
  assign steady     = steady_q;
  assign sample_cnt = cnt_q;

  // Modulo-2^WIDTH difference; clr re-bases against zero in the same cycle.
  assign base = clr ? '0 : prev_q;
  assign diff = q - base;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (emit && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    prev_d   = prev_q;
    a_d      = a_q;
    last_d   = last_q;
    run_d    = run_q;
    steady_d = steady_q;
    cnt_d    = cnt_q;

    if (emit && !(&cnt_q)) cnt_d = cnt_q + 1'b1;

    if (accept) begin
      a_d    = diff;
      prev_d = q;
      last_d = diff;
      if (run_q == '0 || clr || diff != last_q)
        run_d = RUN_CW'(1);
      else if (run_q != RUN_CW'(RUN_LEN))
        run_d = run_q + 1'b1;
      steady_d = (run_d == RUN_CW'(RUN_LEN));
    end else if (clr) begin
      // Re-base only; a pending output is still delivered.
      prev_d   = '0;
      run_d    = '0;
      steady_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= EMPTY;
      prev_q   <= '0;
      a_q      <= '0;
      last_q   <= '0;
      run_q    <= '0;
      steady_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      a_q      <= a_d;
      last_q   <= last_d;
      run_q    <= run_d;
      steady_q <= steady_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
